// File: rtl/sdram_arbiter_if.sv
// sdram_arbiter_if: the two client ports and the SDRAM-controller port.
// The "slave" modport is the arbiter's view of the bundle. The "master"
// modport is the surrounding system's view: the frame-buffer reader,
// the rasterizer/CPU client and the SDRAM controller.
interface sdram_arbiter_if;
    // Port 0: display frame-buffer reader (read-only)
    logic [28:0] m0_address;
    logic        m0_read;
    logic        m0_urgent;
    logic        m0_waitrequest;
    logic [63:0] m0_readdata;
    logic        m0_readdatavalid;
    // Port 1: rasterizer/CPU client (read/write)
    logic [28:0] m1_address;
    logic        m1_read;
    logic        m1_write;
    logic [63:0] m1_writedata;
    logic [7:0]  m1_byteenable;
    logic        m1_waitrequest;
    logic [63:0] m1_readdata;
    logic        m1_readdatavalid;
    // Memory side: SDRAM controller
    logic [28:0] s_address;
    logic [7:0]  s_burstcount;
    logic        s_read;
    logic        s_write;
    logic [63:0] s_writedata;
    logic [7:0]  s_byteenable;
    logic        s_waitrequest;
    logic [63:0] s_readdata;
    logic        s_readdatavalid;

    modport slave (
        input  m0_address, m0_read, m0_urgent,
        output m0_waitrequest, m0_readdata, m0_readdatavalid,
        input  m1_address, m1_read, m1_write, m1_writedata, m1_byteenable,
        output m1_waitrequest, m1_readdata, m1_readdatavalid,
        output s_address, s_burstcount, s_read, s_write, s_writedata, s_byteenable,
        input  s_waitrequest, s_readdata, s_readdatavalid
    );

    modport master (
        output m0_address, m0_read, m0_urgent,
        input  m0_waitrequest, m0_readdata, m0_readdatavalid,
        output m1_address, m1_read, m1_write, m1_writedata, m1_byteenable,
        input  m1_waitrequest, m1_readdata, m1_readdatavalid,
        input  s_address, s_burstcount, s_read, s_write, s_writedata, s_byteenable,
        output s_waitrequest, s_readdata, s_readdatavalid
    );
endinterface

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares one 64-bit Avalon-MM SDRAM port between the display
// reader (port 0) and the rasterizer/CPU client (port 1). Commands pass
// through a registered grant; in-order read responses are steered back to
// the issuing port by a 1-bit tag FIFO. Port 0 wins outright while urgent.
module sdram_arbiter #(
    parameter int MAX_OUTSTANDING  = 32,
    parameter int OUTSTANDING_LOG2 = 5
) (
    input  logic           clock,
    input  logic           reset,
    sdram_arbiter_if.slave bus,
    output logic           error
);
    typedef enum logic {PORT0 = 1'b0, PORT1 = 1'b1} port_t;

    localparam logic [OUTSTANDING_LOG2:0]   FULL_COUNT = (OUTSTANDING_LOG2 + 1)'(MAX_OUTSTANDING);
    localparam logic [OUTSTANDING_LOG2:0]   CNT_ONE    = (OUTSTANDING_LOG2 + 1)'(1);
    localparam logic [OUTSTANDING_LOG2-1:0] LAST_PTR   = OUTSTANDING_LOG2'(MAX_OUTSTANDING - 1);
    localparam logic [OUTSTANDING_LOG2-1:0] PTR_ONE    = OUTSTANDING_LOG2'(1);

    port_t                     grant_r;
    port_t                     last_r;
    port_t                     grant_next_s;
    port_t                     last_next_s;
    logic [OUTSTANDING_LOG2:0] count_r;
    logic [OUTSTANDING_LOG2-1:0] wr_ptr_r;
    logic [OUTSTANDING_LOG2-1:0] rd_ptr_r;
    logic                      tag_mem_r [MAX_OUTSTANDING];
    logic                      error_r;

    logic full_s, empty_s, head_s;
    logic req_read_s, req_write_s, req_any_s;
    logic s_read_s, s_write_s, accept_s;
    logic push_s, pop_s, stray_s;
    logic pend0_s, pend1_s, locked_s;

    // Pointers wrap at the FIFO depth even when it is not a power of two
    function automatic logic [OUTSTANDING_LOG2-1:0] next_ptr(input logic [OUTSTANDING_LOG2-1:0] ptr);
        if (ptr == LAST_PTR) begin
            return {OUTSTANDING_LOG2{1'b0}};
        end else begin
            return ptr + PTR_ONE;
        end
    endfunction

    assign full_s  = (count_r == FULL_COUNT);
    assign empty_s = (count_r == {(OUTSTANDING_LOG2 + 1){1'b0}});
    assign head_s  = tag_mem_r[rd_ptr_r];

    // Command mux: route the granted master onto the memory side
    always_comb begin
        case (grant_r)
            PORT0: begin
                req_read_s         = bus.m0_read;
                req_write_s        = 1'b0;
                bus.s_address      = bus.m0_address;
                bus.s_writedata    = 64'h0;
                bus.s_byteenable   = 8'hFF;
            end
            PORT1: begin
                req_read_s         = bus.m1_read;
                req_write_s        = bus.m1_write;
                bus.s_address      = bus.m1_address;
                bus.s_writedata    = bus.m1_writedata;
                bus.s_byteenable   = bus.m1_byteenable;
            end
            default: begin
                req_read_s         = 1'b0;
                req_write_s        = 1'b0;
                bus.s_address      = 29'h0;
                bus.s_writedata    = 64'h0;
                bus.s_byteenable   = 8'hFF;
            end
        endcase
    end

    // Command gating, stalls and response steering (all forced quiet in reset)
    always_comb begin
        req_any_s            = req_read_s || req_write_s;
        s_read_s             = !reset && req_read_s && !full_s;
        s_write_s            = !reset && req_write_s;
        accept_s             = (s_read_s || s_write_s) && !bus.s_waitrequest;
        push_s               = accept_s && s_read_s;
        pop_s                = bus.s_readdatavalid && !empty_s;
        stray_s              = bus.s_readdatavalid && empty_s;
        bus.s_read           = s_read_s;
        bus.s_write          = s_write_s;
        bus.s_burstcount     = 8'h01;
        bus.m0_waitrequest   = reset || (grant_r != PORT0) || bus.s_waitrequest
                               || (bus.m0_read && full_s);
        bus.m1_waitrequest   = reset || (grant_r != PORT1) || bus.s_waitrequest
                               || (bus.m1_read && full_s);
        bus.m0_readdata      = bus.s_readdata;
        bus.m1_readdata      = bus.s_readdata;
        bus.m0_readdatavalid = !reset && pop_s && (head_s == 1'b0);
        bus.m1_readdatavalid = !reset && pop_s && (head_s == 1'b1);
    end

    // Next-grant decision; a stalled command keeps its grant (and so its address/data)
    always_comb begin
        if (accept_s) begin
            last_next_s = grant_r;
        end else begin
            last_next_s = last_r;
        end
        pend0_s  = bus.m0_read;
        pend1_s  = (bus.m1_read || bus.m1_write) && !(accept_s && (grant_r == PORT1));
        locked_s = req_any_s && !accept_s;
        if (locked_s) begin
            grant_next_s = grant_r;
        end else if (pend0_s && pend1_s) begin
            if (bus.m0_urgent) begin
                grant_next_s = PORT0;
            end else if (last_next_s == PORT0) begin
                grant_next_s = PORT1;
            end else begin
                grant_next_s = PORT0;
            end
        end else if (pend0_s) begin
            grant_next_s = PORT0;
        end else if (pend1_s) begin
            grant_next_s = PORT1;
        end else begin
            grant_next_s = grant_r;
        end
    end

    // Grant, round-robin history, tag pointers, occupancy and sticky error
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            grant_r  <= PORT0;
            last_r   <= PORT1;
            count_r  <= {(OUTSTANDING_LOG2 + 1){1'b0}};
            wr_ptr_r <= {OUTSTANDING_LOG2{1'b0}};
            rd_ptr_r <= {OUTSTANDING_LOG2{1'b0}};
            error_r  <= 1'b0;
        end else begin
            grant_r <= grant_next_s;
            last_r  <= last_next_s;
            if (push_s) begin
                wr_ptr_r <= next_ptr(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= next_ptr(rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
            if (stray_s) begin
                error_r <= 1'b1;
            end
        end
    end

    // Tag storage: which port issued each outstanding read
    always_ff @(posedge clock) begin
        if (push_s) begin
            tag_mem_r[wr_ptr_r] <= (grant_r == PORT1);
        end
    end

    assign error = error_r;
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: randomized masters and an in-order memory model around
// sdram_arbiter. Accepted reads push their expected data (from a reference
// memory image) into per-port queues; a separate monitor pops and compares
// whenever a port strobes readdatavalid. Directed phases cover reset, strict
// round-robin, urgent priority, stall lock, the full boundary and stray data.
module tb_sdram_arbiter;
    logic clock = 1'b0;
    logic reset;
    logic error;

    sdram_arbiter_if bus ();

    sdram_arbiter #(.MAX_OUTSTANDING(32), .OUTSTANDING_LOG2(5)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus),
        .error (error)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // master request state per port
    logic        rq_v  [2];
    logic [28:0] rq_a  [2];
    logic        rq_w  [2];
    logic [63:0] rq_d  [2];
    logic [7:0]  rq_be [2];
    int          budget [2];
    int busy_pct, wr_pct, wait_pct, lat, addr_max;
    logic urg, rst_v, mem_auto, man_pop, stray, force_wait;

    typedef struct { int due; logic [63:0] data; } rsp_t;
    rsp_t        pend [$];
    logic [63:0] ref_mem [int];
    logic [63:0] phy_mem [int];
    logic [63:0] exp0 [$];
    logic [63:0] exp1 [$];
    int          acc_log [$];
    int          acc_cyc [$];

    function automatic logic [63:0] init_word(logic [28:0] a);
        return {35'h0, a} ^ 64'h0123_4567_89AB_CDEF;
    endfunction

    function automatic logic [63:0] merge(logic [63:0] old, logic [63:0] nw, logic [7:0] be);
        for (int i = 0; i < 8; i++) if (be[i]) old[8*i +: 8] = nw[8*i +: 8];
        return old;
    endfunction

    function automatic logic [63:0] rd_ref(logic [28:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return init_word(a);
    endfunction

    function automatic logic [63:0] rd_phy(logic [28:0] a);
        if (phy_mem.exists(int'(a))) return phy_mem[int'(a)];
        return init_word(a);
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // One clock: drive at negedge, sample 1 time unit before the next posedge
    task automatic step();
        @(negedge clock);
        for (int p = 0; p < 2; p++) begin
            if (!rq_v[p] && budget[p] > 0 && int'($urandom_range(0, 99)) < busy_pct) begin
                rq_v[p]  = 1'b1;
                budget[p]--;
                rq_a[p]  = 29'($urandom_range(0, addr_max));
                rq_w[p]  = (p == 1) && (int'($urandom_range(0, 99)) < wr_pct);
                rq_d[p]  = {$urandom, $urandom};
                rq_be[p] = rq_w[p] ? 8'($urandom) : 8'hFF;
            end
        end
        reset              = rst_v;
        bus.m0_address     = rq_a[0];
        bus.m0_read        = rq_v[0];
        bus.m0_urgent      = urg;
        bus.m1_address     = rq_a[1];
        bus.m1_read        = rq_v[1] && !rq_w[1];
        bus.m1_write       = rq_v[1] && rq_w[1];
        bus.m1_writedata   = rq_d[1];
        bus.m1_byteenable  = rq_be[1];
        bus.s_waitrequest  = force_wait || (int'($urandom_range(0, 99)) < wait_pct);
        if (stray) begin
            bus.s_readdatavalid = 1'b1;
            bus.s_readdata      = 64'hBAD0_BAD0_BAD0_BAD0;
        end else if ((mem_auto || man_pop) && pend.size() > 0 && pend[0].due <= cyc) begin
            bus.s_readdatavalid = 1'b1;
            bus.s_readdata      = pend[0].data;
            void'(pend.pop_front());
        end else begin
            bus.s_readdatavalid = 1'b0;
            bus.s_readdata      = {$urandom, $urandom};
        end
        #4;
        if (bus.m0_read && !bus.m0_waitrequest) begin
            exp0.push_back(rd_ref(rq_a[0]));
            acc_log.push_back(0);
            acc_cyc.push_back(cyc);
            rq_v[0] = 1'b0;
        end
        if ((bus.m1_read || bus.m1_write) && !bus.m1_waitrequest) begin
            if (rq_w[1]) ref_mem[int'(rq_a[1])] = merge(rd_ref(rq_a[1]), rq_d[1], rq_be[1]);
            else         exp1.push_back(rd_ref(rq_a[1]));
            acc_log.push_back(1);
            acc_cyc.push_back(cyc);
            rq_v[1] = 1'b0;
        end
        if (bus.s_read && !bus.s_waitrequest)
            pend.push_back('{due: cyc + lat, data: rd_phy(bus.s_address)});
        if (bus.s_write && !bus.s_waitrequest)
            phy_mem[int'(bus.s_address)] = merge(rd_phy(bus.s_address), bus.s_writedata, bus.s_byteenable);
        cyc++;
    endtask

    // Let outstanding requests and responses finish, bounded
    task automatic drain(string name, int limit);
        int n = 0;
        budget[0] = 0; budget[1] = 0;
        force_wait = 1'b0; wait_pct = 0; mem_auto = 1'b1; stray = 1'b0; urg = 1'b0;
        while ((rq_v[0] || rq_v[1] || pend.size() > 0 || exp0.size() > 0 || exp1.size() > 0)
               && n < limit) begin
            step();
            n++;
        end
        step();
        check({name, "_drained"}, 64'(exp0.size() + exp1.size() + pend.size()), 64'd0);
    endtask

    // Response monitor: pop the issuing port's queue on every strobe
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clock);
            #4;
            if (bus.m0_readdatavalid && bus.m1_readdatavalid)
                check("both_rdv", 64'd1, 64'd0);
            if (bus.m0_readdatavalid) begin
                if (exp0.size() == 0) check("m0_unexpected_rdv", 64'd1, 64'd0);
                else begin
                    e = exp0.pop_front();
                    check("m0_readdata", bus.m0_readdata, e);
                end
            end
            if (bus.m1_readdatavalid) begin
                if (exp1.size() == 0) check("m1_unexpected_rdv", 64'd1, 64'd0);
                else begin
                    e = exp1.pop_front();
                    check("m1_readdata", bus.m1_readdata, e);
                end
            end
        end
    end

    // Watchdog against a hung run
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, ones, d, k;
        for (int p = 0; p < 2; p++) begin
            rq_v[p] = 1'b0; rq_a[p] = 29'h0; rq_w[p] = 1'b0; rq_d[p] = 64'h0;
            rq_be[p] = 8'hFF; budget[p] = 0;
        end
        busy_pct = 100; wr_pct = 0; wait_pct = 0; lat = 5; addr_max = 63;
        urg = 1'b0; rst_v = 1'b1; mem_auto = 1'b1; man_pop = 1'b0; stray = 1'b0; force_wait = 1'b0;
        reset = 1'b1;
        bus.m0_address = 29'h0; bus.m0_read = 1'b0; bus.m0_urgent = 1'b0;
        bus.m1_address = 29'h0; bus.m1_read = 1'b0; bus.m1_write = 1'b0;
        bus.m1_writedata = 64'h0; bus.m1_byteenable = 8'h0;
        bus.s_waitrequest = 1'b0; bus.s_readdata = 64'h0; bus.s_readdatavalid = 1'b0;

        // Reset with both masters requesting and a stray strobe
        rq_v[0] = 1'b1; rq_a[0] = 29'h55;
        rq_v[1] = 1'b1; rq_a[1] = 29'h66;
        stray = 1'b1;
        step();
        stray = 1'b0;
        check("rst_s_read",  64'(bus.s_read), 64'd0);
        check("rst_s_write", 64'(bus.s_write), 64'd0);
        check("rst_m0_wait", 64'(bus.m0_waitrequest), 64'd1);
        check("rst_m1_wait", 64'(bus.m1_waitrequest), 64'd1);
        check("rst_rdv",     64'({bus.m0_readdatavalid, bus.m1_readdatavalid}), 64'd0);

        // First cycle after release: port 0 alone at 0x100 goes straight out
        rst_v = 1'b0; rq_v[1] = 1'b0; rq_a[0] = 29'h100;
        step();
        check("post_rst_addr",  64'(bus.s_address), 64'h100);
        check("post_rst_read",  64'(bus.s_read), 64'd1);
        check("post_rst_m0_wr", 64'(bus.m0_waitrequest), 64'd0);
        check("post_rst_error", 64'(error), 64'd0);
        drain("reset", 50);

        // Contention without urgent: accepted ports must alternate
        acc_log.delete(); acc_cyc.delete();
        budget[0] = 1000; budget[1] = 1000; busy_pct = 100; wr_pct = 0;
        n = 0;
        while (acc_log.size() < 200 && n < 1000) begin step(); n++; end
        check("rr_count", 64'(acc_log.size() >= 200), 64'd1);
        for (int i = 1; i < acc_log.size(); i++)
            check("rr_alternate", 64'(acc_log[i]), 64'(1 - acc_log[i-1]));
        drain("rr", 200);

        // Urgent: port 1 gets nothing, then wins within 2 cycles of release
        urg = 1'b1; budget[0] = 1000; budget[1] = 1000;
        repeat (5) step();
        acc_log.delete(); acc_cyc.delete();
        repeat (40) step();
        ones = 0;
        foreach (acc_log[i]) if (acc_log[i] == 1) ones++;
        check("urgent_p1_accepts", 64'(ones), 64'd0);
        check("urgent_p0_accepts", 64'(acc_log.size() - ones), 64'd40);
        urg = 1'b0; k = cyc; d = -1; n = 0;
        acc_log.delete(); acc_cyc.delete();
        while (d < 0 && n < 10) begin
            step(); n++;
            foreach (acc_log[i]) if (acc_log[i] == 1 && d < 0) d = acc_cyc[i] - k;
        end
        check("urgent_release_within_2", 64'(d >= 0 && d <= 2), 64'd1);
        drain("urgent", 100);

        // Lock under stall: port 1 write held 10 cycles, port 0 kept waiting
        force_wait = 1'b1;
        rq_v[1] = 1'b1; rq_w[1] = 1'b1; rq_a[1] = 29'h2A;
        rq_d[1] = 64'hDEADBEEF_CAFEF00D; rq_be[1] = 8'hFF;
        repeat (2) step();
        rq_v[0] = 1'b1; rq_w[0] = 1'b0; rq_a[0] = 29'h11;
        for (int i = 0; i < 10; i++) begin
            step();
            check("stall_addr",    64'(bus.s_address), 64'h2A);
            check("stall_wdata",   bus.s_writedata, 64'hDEADBEEF_CAFEF00D);
            check("stall_write",   64'(bus.s_write), 64'd1);
            check("stall_m0_wait", 64'(bus.m0_waitrequest), 64'd1);
        end
        drain("stall", 50);
        rq_v[0] = 1'b1; rq_a[0] = 29'h2A;
        drain("readback", 50);

        // Full boundary: 32 reads outstanding, the 33rd stalls
        mem_auto = 1'b0; budget[0] = 33; budget[1] = 0; busy_pct = 100;
        acc_log.delete(); acc_cyc.delete();
        n = 0;
        while (acc_log.size() < 32 && n < 200) begin step(); n++; end
        repeat (3) step();
        check("full_accepts",   64'(acc_log.size()), 64'd32);
        check("full_count",     64'(dut.count_r), 64'd32);
        check("full_m0_wait",   64'(bus.m0_read && bus.m0_waitrequest), 64'd1);
        check("full_s_read",    64'(bus.s_read), 64'd0);
        man_pop = 1'b1;
        step();
        man_pop = 1'b0;
        check("full_pop_rdv",     64'(bus.m0_readdatavalid), 64'd1);
        check("full_pop_stalled", 64'(bus.s_read || !bus.m0_waitrequest), 64'd0);
        step();
        check("full_accept_next", 64'(bus.s_read && !bus.m0_waitrequest), 64'd1);
        drain("full", 300);

        // Randomized mix: writes, random stalls, random urgency
        budget[0] = 150; budget[1] = 150; busy_pct = 60; wr_pct = 40;
        wait_pct = 25; lat = 3; addr_max = 15;
        n = 0;
        while ((budget[0] > 0 || budget[1] > 0) && n < 3000) begin
            urg = ($urandom_range(0, 3) == 0);
            step(); n++;
        end
        check("random_budget_used", 64'(budget[0] + budget[1]), 64'd0);
        drain("random", 300);

        // Stray response with nothing outstanding
        check("err_before_stray", 64'(error), 64'd0);
        stray = 1'b1;
        step();
        stray = 1'b0;
        check("stray_rdv", 64'({bus.m0_readdatavalid, bus.m1_readdatavalid}), 64'd0);
        step();
        check("stray_error_set", 64'(error), 64'd1);
        repeat (5) step();
        check("stray_error_held", 64'(error), 64'd1);
        rst_v = 1'b1;
        step();
        rst_v = 1'b0;
        check("error_cleared_by_reset", 64'(error), 64'd0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
